seq_mult: RTL and testbench

Parametrised sequential shift-add multiplier: WIDTH×WIDTH operands, 2·WIDTH-bit product, one partial-product step per clock. It is the area-reduced successor of the 4-bit combinational array multiplier. It also serves as the multiply unit in the datapath labs. A single adder, reused WIDTH times, replaces the WIDTH−1 ripple-carry rows. A start/busy/done handshake and an optional signed (Booth radix-2) mode are added.

---
 rtl/seq_mult_if.sv | 23 ++
 rtl/seq_mult.sv | 144 ++++++++++++++
 tb/tb_seq_mult.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_if.sv
// Handshake and operand/result bundle for seq_mult.
// The master drives the request; the slave (the multiplier) returns the status and the product.
interface seq_mult_if #(
   parameter int WIDTH = 8
);
   logic                   start;
   logic                   signed_op;
   logic [WIDTH-1:0]       x;
   logic [WIDTH-1:0]       y;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     p;

   modport master (
      output start, signed_op, x, y,
      input  busy, done, p
   );

   modport slave (
      input  start, signed_op, x, y,
      output busy, done, p
   );
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// Define SEQ_MULT_SIGNED_EN to compile in the Booth radix-2 signed mode selected by signed_op.
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   seq_mult_if.slave     bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       m_q, m_d;
   logic [WIDTH-1:0]       q_q, q_d;
   logic [WIDTH:0]         a_q, a_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     p_q, p_d;

   logic [WIDTH:0]         sum;
   logic                   shift_in;

`ifdef SEQ_MULT_SIGNED_EN
   logic                   qm1_q, qm1_d;
   logic                   mode_q, mode_d;
   logic [WIDTH:0]         m_sext;

   assign m_sext = {m_q[WIDTH-1], m_q};
`else
   logic                   unused_signed_op;

   assign unused_signed_op = bus.signed_op;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         q_q     <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         qm1_q   <= 1'b0;
         mode_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
`ifdef SEQ_MULT_SIGNED_EN
         qm1_q   <= qm1_d;
         mode_q  <= mode_d;
`endif
      end
   end

   // Partial-product step: conditional add (or Booth add/subtract), then the shift-in bit for A.
   always_comb begin
      sum      = a_q;
      shift_in = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      if (mode_q) begin
         unique case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_sext;
            2'b10:   sum = a_q - m_sext;
            default: sum = a_q;
         endcase
         shift_in = sum[WIDTH];
      end else if (q_q[0]) begin
         sum = a_q + {1'b0, m_q};
      end
`else
      if (q_q[0]) begin
         sum = a_q + {1'b0, m_q};
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
`ifdef SEQ_MULT_SIGNED_EN
      qm1_d   = qm1_q;
      mode_d  = mode_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               m_d     = bus.x;
               q_d     = bus.y;
               a_d     = '0;
               cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
               qm1_d   = 1'b0;
               mode_d  = bus.signed_op;
`endif
            end
         end

         RUN: begin
            a_d   = {shift_in, sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
            qm1_d = q_q[0];
`endif
            cnt_d = cnt_q + 1'b1;
            // The product is taken from the post-shift values of the final step.
            if (cnt_q == CW'(WIDTH - 1)) begin
               p_d     = {a_d[WIDTH-1:0], q_d};
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (WIDTH=8): vector table plus handshake and reset sequences.
module tb_seq_mult;

   localparam int W = 8;

   logic clk;
   logic rst;

   seq_mult_if #(.WIDTH(W)) bus ();

   seq_mult #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0]   x;
      logic [W-1:0]   y;
      logic           s;
      logic [2*W-1:0] exp_p;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full operation; checks latency, busy length, held p during RUN, result and single-cycle done.
   task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [2*W-1:0] exp_p, input string name);
      logic [2*W-1:0] prev_p;
      int lat;
      int busy_cnt;
      bit p_held;
      bit seen;
      prev_p    = bus.p;
      bus.x     = x;
      bus.y     = y;
      bus.signed_op = s;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.x     = ~x;
      bus.y     = ~y;
      bus.signed_op = ~s;
      lat = 0;
      busy_cnt = 0;
      p_held = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cnt++;
         if (bus.p !== prev_p) p_held = 1'b0;
         tick();
         lat++;
      end
      chk({name, "_seen"}, 32'(seen), 32'd1);
      chk({name, "_lat"}, 32'(lat), 32'(W));
      chk({name, "_busy"}, 32'(busy_cnt), 32'(W));
      chk({name, "_hold"}, 32'(p_held), 32'd1);
      chk({name, "_p"}, 32'(bus.p), 32'(exp_p));
      tick();
      chk({name, "_dfall"}, 32'(bus.done), 32'd0);
      chk({name, "_pkeep"}, 32'(bus.p), 32'(exp_p));
   endtask

   vec_t vecs[7];

   initial begin
      int dcount;
      vecs[0] = '{x: 8'd13,  y: 8'd11,  s: 1'b0, exp_p: 16'h008F};
      vecs[1] = '{x: 8'd255, y: 8'd255, s: 1'b0, exp_p: 16'hFE01};
      vecs[2] = '{x: 8'd0,   y: 8'd200, s: 1'b0, exp_p: 16'h0000};
`ifdef SEQ_MULT_SIGNED_EN
      vecs[3] = '{x: 8'hFD,  y: 8'd5,   s: 1'b1, exp_p: 16'hFFF1};
      vecs[4] = '{x: 8'h80,  y: 8'h80,  s: 1'b1, exp_p: 16'h4000};
      vecs[5] = '{x: 8'h7F,  y: 8'h80,  s: 1'b1, exp_p: 16'hC080};
      vecs[6] = '{x: 8'hFF,  y: 8'hFF,  s: 1'b1, exp_p: 16'h0001};
`else
      vecs[3] = '{x: 8'hFD,  y: 8'd5,   s: 1'b1, exp_p: 16'h04F1};
      vecs[4] = '{x: 8'h80,  y: 8'h80,  s: 1'b1, exp_p: 16'h4000};
      vecs[5] = '{x: 8'h7F,  y: 8'h80,  s: 1'b1, exp_p: 16'h3F80};
      vecs[6] = '{x: 8'hFF,  y: 8'hFF,  s: 1'b1, exp_p: 16'hFE01};
`endif

      rst = 1'b1;
      bus.start = 1'b0;
      bus.signed_op = 1'b0;
      bus.x = '0;
      bus.y = '0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_p", 32'(bus.p), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         do_mult(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].exp_p, $sformatf("vec%0d", i));
         tick();
      end

      // Start re-asserted while busy and held through DONE.
      bus.x = 8'd13;
      bus.y = 8'd11;
      bus.signed_op = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      bus.x = 8'd2;
      bus.y = 8'd3;
      bus.start = 1'b1;
      dcount = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) break;
         tick();
      end
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_p", 32'(bus.p), 32'h008F);
      tick();
      chk("hold_idle_busy", 32'(bus.busy), 32'd0);
      chk("hold_idle_done", 32'(bus.done), 32'd0);
      tick();
      chk("hold_accept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) dcount++;
         tick();
      end
      chk("hold_dcount", 32'(dcount), 32'd1);
      chk("hold_p2", 32'(bus.p), 32'd6);

      // Reset four cycles into RUN discards the operation.
      bus.x = 8'd13;
      bus.y = 8'd11;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("mid_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_done", 32'(bus.done), 32'd0);
      chk("mid_p", 32'(bus.p), 32'd0);
      tick();
      rst = 1'b0;
      dcount = 0;
      for (int k = 0; k < 15; k++) begin
         if (bus.done || bus.busy) dcount++;
         tick();
      end
      chk("mid_nodone", 32'(dcount), 32'd0);
      do_mult(8'd6, 8'd7, 1'b0, 16'd42, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
